// File: rtl/game_tile_probe.sv
// Per-frame foot-probe sampler: on each vsync rising edge read three tile codes
// under the player's feet, resolve them by priority and debounce across frames.
module game_tile_probe #(
  parameter int PLAYER_W      = 32,
  parameter int PLAYER_H      = 48,
  parameter int FOOT_INSET    = 4,
  parameter int TILE_LOG2     = 4,
  parameter int MAP_W_LOG2    = 6,
  parameter int MAP_H         = 48,
  parameter int STABLE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic        map_rd,
  output logic [11:0] map_addr,
  input  logic [3:0]  map_data,
  output logic [3:0]  current_pix,
  output logic        pix_changed
);

  typedef enum logic [2:0] {IDLE, RD_C, CAP_C, RD_L, CAP_L, RD_R, CAP_R, RESOLVE} state_t;

  localparam logic [1:0] P_C = 2'd0;
  localparam logic [1:0] P_L = 2'd1;
  localparam logic [1:0] P_R = 2'd2;

  // Returns {oob, map address} for one probe point of a sprite at (x, y).
  function automatic logic [12:0] probe(input logic [11:0] x, input logic [11:0] y,
                                        input logic [1:0] sel);
    logic [12:0] px, py, tx, ty;
    logic        oob;
    case (sel)
      P_L:     px = {1'b0, x} + 13'(FOOT_INSET);
      P_R:     px = {1'b0, x} + 13'(PLAYER_W - 1 - FOOT_INSET);
      default: px = {1'b0, x} + 13'(PLAYER_W / 2);
    endcase
    py  = {1'b0, y} + 13'(PLAYER_H - 1);
    tx  = px >> TILE_LOG2;
    ty  = py >> TILE_LOG2;
    oob = px[12] | py[12] | (tx >= 13'(1 << MAP_W_LOG2)) | (ty >= 13'(MAP_H));
    return {oob, ty[11-MAP_W_LOG2:0], tx[MAP_W_LOG2-1:0]};
  endfunction

  state_t      state_q;
  logic        vsync_d_q;
  logic [11:0] x_q, y_q;
  logic [3:0]  code_c_q, code_l_q, code_r_q;
  logic [3:0]  last_cand_q, stable_cnt_q;
  logic        oob_q;
  logic        map_rd_q;
  logic [11:0] map_addr_q;
  logic [3:0]  cur_q;
  logic        chg_q;

  logic        fire;
  logic [12:0] probe_d;
  logic [3:0]  cand_d, cnt_d;
  logic        upd_d;

  assign fire = vsync & ~vsync_d_q;

  // The probe issued on leaving a state; IDLE uses the live position since it
  // is being latched on the same edge.
  always_comb begin
    probe_d = probe(x_q, y_q, P_C);
    case (state_q)
      IDLE:    probe_d = probe(xpos, ypos, P_C);
      CAP_C:   probe_d = probe(x_q, y_q, P_L);
      CAP_L:   probe_d = probe(x_q, y_q, P_R);
      default: probe_d = probe(x_q, y_q, P_C);
    endcase
  end

  always_comb begin
    cand_d = (code_c_q != 4'd0) ? code_c_q :
             (code_l_q != 4'd0) ? code_l_q : code_r_q;
    if (cand_d == last_cand_q)
      cnt_d = (stable_cnt_q == 4'd15) ? 4'd15 : stable_cnt_q + 4'd1;
    else
      cnt_d = 4'd1;
    upd_d = (cnt_d >= 4'(STABLE_FRAMES)) && (cand_d != cur_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      vsync_d_q    <= 1'b1;
      x_q          <= '0;
      y_q          <= '0;
      code_c_q     <= '0;
      code_l_q     <= '0;
      code_r_q     <= '0;
      last_cand_q  <= '0;
      stable_cnt_q <= '0;
      oob_q        <= 1'b0;
      map_rd_q     <= 1'b0;
      map_addr_q   <= '0;
      cur_q        <= '0;
      chg_q        <= 1'b0;
    end else begin
      vsync_d_q <= vsync;
      map_rd_q  <= 1'b0;
      chg_q     <= 1'b0;
      case (state_q)
        IDLE: if (fire) begin
          x_q      <= xpos;
          y_q      <= ypos;
          oob_q    <= probe_d[12];
          map_rd_q <= ~probe_d[12];
          if (!probe_d[12]) map_addr_q <= probe_d[11:0];
          state_q  <= RD_C;
        end
        RD_C: state_q <= CAP_C;
        CAP_C: begin
          code_c_q <= oob_q ? 4'd0 : map_data;
          oob_q    <= probe_d[12];
          map_rd_q <= ~probe_d[12];
          if (!probe_d[12]) map_addr_q <= probe_d[11:0];
          state_q  <= RD_L;
        end
        RD_L: state_q <= CAP_L;
        CAP_L: begin
          code_l_q <= oob_q ? 4'd0 : map_data;
          oob_q    <= probe_d[12];
          map_rd_q <= ~probe_d[12];
          if (!probe_d[12]) map_addr_q <= probe_d[11:0];
          state_q  <= RD_R;
        end
        RD_R: state_q <= CAP_R;
        CAP_R: begin
          code_r_q <= oob_q ? 4'd0 : map_data;
          state_q  <= RESOLVE;
        end
        RESOLVE: begin
          last_cand_q  <= cand_d;
          stable_cnt_q <= cnt_d;
          if (upd_d) begin
            cur_q <= cand_d;
            chg_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign map_rd      = map_rd_q;
  assign map_addr    = map_addr_q;
  assign current_pix = cur_q;
  assign pix_changed = chg_q;

endmodule
